// File: rtl/sc_pkg.sv
// sc_pkg: shared FSM states, bit-rotate helper and default Galois taps per LFSR width.
package sc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
  function automatic logic [63:0] default_taps(input int unsigned n);
    return n == 4 ? 64'hC : n == 8 ? 64'hB8 : n == 16 ? 64'hB400 : n == 32 ? 64'hA300_0000 : 64'h0;
  endfunction
  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned amt, input int unsigned n);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++)
      if (i < n) r[6'((i + amt) % n)] = v[6'(i)];
    return r;
  endfunction
endpackage

// File: rtl/sc_lfsr_galois.sv
// sc_lfsr_galois: Galois LFSR that steps on en_i and loads load_val_i, replacing a zero load with SEED.
module sc_lfsr_galois
  import sc_pkg::*;
#(
  parameter int N = 16,
  parameter logic [N-1:0] TAPS = N'(default_taps(N)),
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  output logic [N-1:0] state_o
);
  logic [N-1:0] state_q, state_d;
  always_comb
    state_d = load_i ? (load_val_i == '0 ? SEED : load_val_i)
            : en_i   ? (state_q[0] ? (state_q >> 1) ^ TAPS : state_q >> 1)
            : state_q;
  always_ff @(posedge clk_i)
    state_q <= reset_i ? SEED : state_d;
  assign state_o = state_q;
endmodule

// File: rtl/sc_bitstream_gen.sv
// sc_bitstream_gen: multi-channel stochastic bitstream generator driven by one Galois LFSR.
// Define SC_BGEN_ONES_COUNT_EN to add per-channel ones counters on ones_cnt_o.
module sc_bitstream_gen
  import sc_pkg::*;
#(
  parameter int N = 16,
  parameter logic [N-1:0] TAPS = N'(default_taps(N)),
  parameter logic [N-1:0] SEED = N'(1),
  parameter int CH = 2,
  parameter int ROT = 5,
  parameter int LEN_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              seed_load_i,
  input  logic [N-1:0]      seed_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CH*N-1:0]   x_i,
  output logic              busy_o,
  output logic              stream_valid_o,
  output logic [CH-1:0]     bits_o,
  output logic              done_o,
  output logic [N-1:0]      lfsr_out_o
`ifdef SC_BGEN_ONES_COUNT_EN
  ,
  output logic [CH*LEN_W-1:0] ones_cnt_o
`endif
);
  fsm_e fsm_q, fsm_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [CH*N-1:0] x_q;
  logic [CH-1:0] bits_q, cmp;
  logic valid_q, done_q, idle_start;
  logic [N-1:0] state;
  assign idle_start = fsm_q == IDLE && start_i;
  sc_lfsr_galois #(.N(N), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (fsm_q == RUN),
    .load_i     (fsm_q == IDLE && seed_load_i),
    .load_val_i (seed_i),
    .state_o    (state)
  );
  // Each channel compares its own rotated view of the shared state, decorrelating the streams.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam int unsigned A = (k * ROT) % N;
    logic [N-1:0] r;
    assign r = N'(rotl(64'(state), A, N));
    assign cmp[k] = r <= x_q[k*N +: N];
  end
  always_comb
    fsm_d = fsm_q == IDLE ? (start_i ? (len_i == '0 ? DONE : RUN) : IDLE)
          : fsm_q == RUN  ? (cnt_q + 1'b1 == len_q ? DONE : RUN)
          : IDLE;
  always_ff @(posedge clk_i)
    fsm_q <= reset_i ? IDLE : fsm_d;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= fsm_q == RUN;
      bits_q  <= fsm_q == RUN ? cmp : '0;
      done_q  <= fsm_q == DONE;
      cnt_q   <= fsm_q == RUN ? cnt_q + 1'b1 : '0;
      if (idle_start) begin
        len_q <= len_i;
        x_q   <= x_i;
      end
    end
  end
`ifdef SC_BGEN_ONES_COUNT_EN
  logic [CH*LEN_W-1:0] ones_q;
  always_ff @(posedge clk_i)
    for (int k = 0; k < CH; k++)
      if (reset_i || idle_start) ones_q[k*LEN_W +: LEN_W] <= '0;
      else if (fsm_q == RUN && cmp[k]) ones_q[k*LEN_W +: LEN_W] <= ones_q[k*LEN_W +: LEN_W] + 1'b1;
  assign ones_cnt_o = ones_q;
`endif
  assign busy_o         = fsm_q == RUN;
  assign stream_valid_o = valid_q;
  assign bits_o         = bits_q;
  assign done_o         = done_q;
  assign lfsr_out_o     = state;
endmodule

// File: tb/tb_sc_bitstream_gen.sv
// tb_sc_bitstream_gen: randomized scoreboard bench for sc_bitstream_gen (N=4, TAPS=C, CH=2, ROT=1).
module tb_sc_bitstream_gen;
  localparam int N = 4, CH = 2, ROT = 1, LEN_W = 16, XW = CH * N;
  localparam int TAPS_I = 'hC, SEED_I = 1, MASK = (1 << N) - 1;
  logic clk = 1'b0, reset, seed_load, start, busy, stream_valid, done;
  logic [N-1:0] seed, lfsr_out;
  logic [LEN_W-1:0] len;
  logic [XW-1:0] x;
  logic [CH-1:0] bits;
`ifdef SC_BGEN_ONES_COUNT_EN
  logic [CH*LEN_W-1:0] ones_cnt;
`endif
  int checks = 0, fails = 0, beats = 0, b0 = 0, m_state = SEED_I;
  int exp_bits[$], exp_lfsr[$], obs_lfsr[$];
  int obs_ones[CH], exp_ones[CH];
  sc_bitstream_gen #(.N(N), .TAPS(4'hC), .SEED(4'h1), .CH(CH), .ROT(ROT), .LEN_W(LEN_W)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .seed_load_i    (seed_load),
    .seed_i         (seed),
    .start_i        (start),
    .len_i          (len),
    .x_i            (x),
    .busy_o         (busy),
    .stream_valid_o (stream_valid),
    .bits_o         (bits),
    .done_o         (done),
    .lfsr_out_o     (lfsr_out)
`ifdef SC_BGEN_ONES_COUNT_EN
    ,
    .ones_cnt_o     (ones_cnt)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic int step(input int s);
    return (s & 1) != 0 ? ((s >> 1) ^ TAPS_I) : (s >> 1);
  endfunction
  function automatic int rot(input int s, input int a);
    return ((s << a) | (s >> (N - a))) & MASK;
  endfunction
  // Monitor: every valid beat is popped against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (stream_valid) begin
      beats++;
      obs_lfsr.push_back(int'(lfsr_out));
      for (int k = 0; k < CH; k++) obs_ones[k] += int'(bits[k]);
      if (exp_bits.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat: got bits %0d with empty scoreboard", bits);
      end else begin
        check("bits", int'(bits), exp_bits.pop_front());
        check("lfsr_beat", int'(lfsr_out), exp_lfsr.pop_front());
      end
    end else if (bits != '0) check("bits_when_invalid", int'(bits), 0);
  end
  task automatic issue(input int x0, input int x1, input int l, input int sl, input int sd);
    int s, b;
    @(negedge clk);
    if (sl != 0) m_state = sd == 0 ? SEED_I : sd;
    s = m_state;
    for (int k = 0; k < CH; k++) begin
      exp_ones[k] = 0;
      obs_ones[k] = 0;
    end
    for (int i = 0; i < l; i++) begin
      b = 0;
      for (int k = 0; k < CH; k++)
        if (rot(s, (k * ROT) % N) <= (k == 0 ? x0 : x1)) begin
          b |= 1 << k;
          exp_ones[k]++;
        end
      s = step(s);
      exp_bits.push_back(b);
      exp_lfsr.push_back(s);
    end
    m_state = s;
    obs_lfsr.delete();
    b0 = beats;
    seed_load = sl != 0;
    seed = N'(sd);
    start = 1'b1;
    len = LEN_W'(l);
    x = {N'(x1), N'(x0)};
    @(posedge clk);
    #1;
    check("busy_at_start", int'(busy), int'(l != 0));
    seed_load = 1'b0;
    start = 1'b0;
    x = XW'($urandom);
    len = LEN_W'($urandom);
  endtask
  task automatic stream(input int x0, input int x1, input int l, input int sl, input int sd, input int poke);
    int got, nb;
    issue(x0, x1, l, sl, sd);
    got = -1;
    nb = int'(busy);
    for (int c = 1; c <= l + 8; c++) begin
      @(posedge clk);
      #1;
      if (poke != 0 && c == 2) begin
        seed_load = 1'b1;
        seed = N'($urandom);
        start = 1'b1;
        len = LEN_W'($urandom_range(1, 9));
      end else begin
        seed_load = 1'b0;
        start = 1'b0;
      end
      nb += int'(busy);
      if (done) begin
        got = c;
        break;
      end
    end
    seed_load = 1'b0;
    start = 1'b0;
    check("done_latency", got, l + 1);
    check("busy_cycles", nb, l);
    check("beat_count", beats - b0, l);
    check("scoreboard_drained", exp_bits.size(), 0);
    check("lfsr_after_done", int'(lfsr_out), m_state);
    for (int k = 0; k < CH; k++) begin
      check("ones_seen", obs_ones[k], exp_ones[k]);
      if (l == 15) check("full_period_ones", obs_ones[k], k == 0 ? x0 : x1);
`ifdef SC_BGEN_ONES_COUNT_EN
      check("ones_cnt", int'(ones_cnt[k*LEN_W +: LEN_W]), exp_ones[k]);
`endif
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", int'(done), 0);
  endtask
  initial begin
    int tbl[16] = '{1, 'hC, 6, 3, 'hD, 'hA, 5, 'hE, 7, 'hF, 'hB, 9, 8, 4, 2, 1};
    int nd, l;
    reset = 1'b1;
    seed_load = 1'b0;
    start = 1'b0;
    seed = '0;
    len = '0;
    x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(stream_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_bits", int'(bits), 0);
    check("rst_lfsr", int'(lfsr_out), SEED_I);
    @(negedge clk);
    reset = 1'b0;
    stream(3, 9, 15, 1, 1, 0);
    for (int i = 0; i < 15; i++) check("orbit", i < obs_lfsr.size() ? obs_lfsr[i] : -1, tbl[i+1]);
    check("orbit_wrap", int'(lfsr_out), 1);
    stream(8, 8, 15, 0, 0, 0);
    for (int k = 0; k < CH; k++) check("x8_ones", obs_ones[k], 8);
    stream(5, 5, 0, 0, 0, 0);
    stream(7, 2, 3, 1, 0, 0);
    check("zero_seed_subst", obs_lfsr.size() > 0 ? obs_lfsr[0] : -1, 'hC);
    stream(6, 9, 12, 0, 0, 1);
    stream(0, 15, 200, 0, 0, 0);
    check("x0_all_zero", obs_ones[0], 0);
    check("xmax_all_one", obs_ones[1], 200);
    issue(9, 4, 20, 1, 5);
    nd = 0;
    while (beats - b0 < 5 && nd < 40) begin
      @(negedge clk);
      nd++;
    end
    check("reached_bit5", beats - b0, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(stream_valid), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_lfsr", int'(lfsr_out), SEED_I);
    @(negedge clk);
    reset = 1'b0;
    exp_bits.delete();
    exp_lfsr.delete();
    m_state = SEED_I;
    nd = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      nd += int'(done) + int'(stream_valid);
    end
    check("no_done_after_reset", nd, 0);
    repeat (30) begin
      l = $urandom_range(0, 40);
      stream($urandom_range(0, 15), $urandom_range(0, 15), l, $urandom_range(0, 1), $urandom_range(0, 15),
             l >= 3 ? $urandom_range(0, 1) : 0);
    end
    repeat (4) stream($urandom_range(0, 15), $urandom_range(0, 15), 15, 1, $urandom_range(0, 15), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
